// File: rtl/issue_scoreboard_if.sv
// Decode-to-issue handshake, writeback/load completion returns, drain control and status.
// master drives decode-side inputs; slave is the scoreboard.
interface issue_scoreboard_if #(parameter int STALL_W = 16);
  logic               in_valid;
  logic [4:0]         in_rd;
  logic [4:0]         in_rs1;
  logic [4:0]         in_rs2;
  logic               in_rd_valid;
  logic               in_rs1_valid;
  logic               in_rs2_valid;
  logic               in_is_load;
  logic               in_ready;
  logic               issue;
  logic               wb_valid;
  logic [4:0]         wb_rd;
  logic               load_done;
  logic               drain_req;
  logic               drained;
  logic [31:0]        busy_mask;
  logic [2:0]         load_count;
  logic [STALL_W-1:0] stall_count;

  modport master (
    output in_valid, in_rd, in_rs1, in_rs2, in_rd_valid, in_rs1_valid, in_rs2_valid,
           in_is_load, wb_valid, wb_rd, load_done, drain_req,
    input  in_ready, issue, drained, busy_mask, load_count, stall_count
  );

  modport slave (
    input  in_valid, in_rd, in_rs1, in_rs2, in_rd_valid, in_rs1_valid, in_rs2_valid,
           in_is_load, wb_valid, wb_rd, load_done, drain_req,
    output in_ready, issue, drained, busy_mask, load_count, stall_count
  );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue gate: RAW/WAW scoreboard, outstanding-load limit, stall counter
// and a drain sequence that empties the pipeline for debug/CSR writes.
module issue_scoreboard #(
  parameter int MAX_LOADS = 2,
  parameter int STALL_W   = 16
) (
  input logic               clk,
  input logic               reset,
  issue_scoreboard_if.slave sb
);

  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

  state_t             state;
  logic [31:0]        busy_q;
  logic [2:0]         loads_q;
  logic [STALL_W-1:0] stall_q;
  logic               drained_q;

  logic [31:0] wb_clr;
  logic [31:0] eff;
  logic [31:0] rd_set;
  logic        hazard;
  logic        load_block;
  logic        ready;
  logic        fire;
  logic        empty;
  logic        load_inc;
  logic        load_dec;

  // A same-cycle writeback bypasses its register, so it is removed before the hazard check.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wb_clr = '0;
    if (sb.wb_valid) wb_clr[sb.wb_rd] = 1'b1;
    eff = busy_q & ~wb_clr;
  end

  always_comb begin
    hazard = (sb.in_rs1_valid && (sb.in_rs1 != 5'd0) && eff[sb.in_rs1]) ||
             (sb.in_rs2_valid && (sb.in_rs2 != 5'd0) && eff[sb.in_rs2]) ||
             (sb.in_rd_valid  && (sb.in_rd  != 5'd0) && eff[sb.in_rd]);
    load_block = sb.in_is_load && (loads_q == 3'(MAX_LOADS));
    ready      = !reset && (state == RUN) && !sb.drain_req && !hazard && !load_block;
    fire       = sb.in_valid && ready;
    empty      = (busy_q == '0) && (loads_q == '0) && !sb.wb_valid;
    load_inc   = fire && sb.in_is_load;
    load_dec   = sb.load_done && (loads_q != '0);
  end

  always_comb begin
    rd_set = '0;
    if (fire && sb.in_rd_valid && (sb.in_rd != 5'd0)) rd_set[sb.in_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state     <= RUN;
      busy_q    <= '0;
      loads_q   <= '0;
      stall_q   <= '0;
      drained_q <= 1'b0;
    end else begin
      // Set is OR'd after the clear so the newer instruction keeps ownership.
      busy_q <= (busy_q & ~wb_clr) | rd_set;

      if (load_inc && !load_dec)      loads_q <= loads_q + 3'd1;
      else if (load_dec && !load_inc) loads_q <= loads_q - 3'd1;

      if ((state == RUN) && sb.in_valid && !ready && (stall_q != '1))
        stall_q <= stall_q + 1'b1;

      case (state)
        RUN: begin
          if (sb.drain_req) state <= DRAIN;
        end
        DRAIN: begin
          if (!sb.drain_req) begin
            state <= RUN;
          end else if (empty) begin
            state     <= DRAINED;
            drained_q <= 1'b1;
          end
        end
        DRAINED: begin
          if (!sb.drain_req) begin
            state     <= RUN;
            drained_q <= 1'b0;
          end
        end
        default: begin
          state     <= RUN;
          drained_q <= 1'b0;
        end
      endcase
    end
  end

  assign sb.in_ready    = ready;
  assign sb.issue       = fire;
  assign sb.drained     = drained_q;
  assign sb.busy_mask   = busy_q;
  assign sb.load_count  = loads_q;
  assign sb.stall_count = stall_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized plus directed bench for issue_scoreboard against a set/array-based
// reference model of pending writers, outstanding loads and drain mode.
module tb_issue_scoreboard;
  localparam int MAX_LOADS = 2;
  localparam int STALL_W   = 16;
  localparam int SMAX      = (1 << STALL_W) - 1;

  localparam int M_RUN     = 0;
  localparam int M_DRAIN   = 1;
  localparam int M_DRAINED = 2;

  typedef struct {
    bit       rst;
    bit       valid;
    bit [4:0] rd, rs1, rs2;
    bit       rdv, r1v, r2v, ld;
    bit       wb;
    bit [4:0] wbrd;
    bit       done;
    bit       drain;
  } stim_t;

  logic clk;
  logic reset;

  issue_scoreboard_if #(.STALL_W(STALL_W)) sb ();

  issue_scoreboard #(.MAX_LOADS(MAX_LOADS), .STALL_W(STALL_W)) dut (
    .clk  (clk),
    .reset(reset),
    .sb   (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total;
  int checks_passed;

  // Reference model state.
  bit          pending [32];
  int          loads;
  int          mode;
  int unsigned stalls;
  bit          drain_lvl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    for (int r = 1; r < 32; r++) m[r] = pending[r];
    return m;
  endfunction

  function automatic bit model_empty();
    for (int r = 0; r < 32; r++) if (pending[r]) return 1'b0;
    return loads == 0;
  endfunction

  function automatic bit blocked_by(input bit v, input bit [4:0] idx, input stim_t s);
    return v && idx != 0 && pending[idx] && !(s.wb && s.wbrd == idx);
  endfunction

  function automatic stim_t idle(input bit drain = 1'b0);
    stim_t s = '{default: '0};
    s.drain = drain;
    return s;
  endfunction

  function automatic stim_t instr(input int rd, input int rs1, input int rs2,
                                  input bit rdv, input bit r1v, input bit r2v, input bit ld);
    stim_t s = '{default: '0};
    s.valid = 1'b1;
    s.rd = 5'(rd); s.rs1 = 5'(rs1); s.rs2 = 5'(rs2);
    s.rdv = rdv; s.r1v = r1v; s.r2v = r2v; s.ld = ld;
    return s;
  endfunction

  function automatic stim_t with_wb(input stim_t s0, input int r);
    stim_t s = s0;
    s.wb = 1'b1;
    s.wbrd = 5'(r);
    return s;
  endfunction

  // One cycle: check registered outputs, drive, check combinational outputs, advance model.
  task automatic step(input stim_t s);
    bit rdy, iss, emp;
    int l0;
    check("busy_mask",   sb.busy_mask,   model_mask());
    check("load_count",  32'(sb.load_count), 32'(loads));
    check("stall_count", 32'(sb.stall_count), stalls);
    check("drained",     32'(sb.drained), 32'(mode == M_DRAINED));

    reset           = s.rst;
    sb.in_valid     = s.valid;
    sb.in_rd        = s.rd;
    sb.in_rs1       = s.rs1;
    sb.in_rs2       = s.rs2;
    sb.in_rd_valid  = s.rdv;
    sb.in_rs1_valid = s.r1v;
    sb.in_rs2_valid = s.r2v;
    sb.in_is_load   = s.ld;
    sb.wb_valid     = s.wb;
    sb.wb_rd        = s.wbrd;
    sb.load_done    = s.done;
    sb.drain_req    = s.drain;
    #1;

    rdy = !s.rst && mode == M_RUN && !s.drain &&
          !blocked_by(s.r1v, s.rs1, s) && !blocked_by(s.r2v, s.rs2, s) &&
          !blocked_by(s.rdv, s.rd, s) && !(s.ld && loads == MAX_LOADS);
    iss = s.valid && rdy;
    check("in_ready", 32'(sb.in_ready), 32'(rdy));
    check("issue",    32'(sb.issue),    32'(iss));

    if (s.rst) begin
      foreach (pending[r]) pending[r] = 1'b0;
      loads = 0; mode = M_RUN; stalls = 0;
    end else begin
      emp = model_empty() && !s.wb;
      if (mode == M_RUN && s.valid && !rdy && stalls < SMAX) stalls++;
      if (s.wb) pending[s.wbrd] = 1'b0;
      if (iss && s.rdv && s.rd != 0) pending[s.rd] = 1'b1;
      l0 = loads;
      loads = l0 + ((iss && s.ld) ? 1 : 0) - ((s.done && l0 > 0) ? 1 : 0);
      case (mode)
        M_RUN:     if (s.drain) mode = M_DRAIN;
        M_DRAIN:   if (!s.drain) mode = M_RUN; else if (emp) mode = M_DRAINED;
        default:   if (!s.drain) mode = M_RUN;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic stim_t rand_stim();
    stim_t s = '{default: '0};
    s.rst   = ($urandom_range(0, 299) == 0);
    s.valid = ($urandom_range(0, 3) != 0);
    s.rd    = 5'($urandom_range(0, 15));
    s.rs1   = 5'($urandom_range(0, 15));
    s.rs2   = 5'($urandom_range(0, 15));
    s.rdv   = ($urandom_range(0, 3) != 0);
    s.r1v   = $urandom_range(0, 1);
    s.r2v   = $urandom_range(0, 1);
    s.ld    = ($urandom_range(0, 2) == 0);
    s.wb    = ($urandom_range(0, 2) == 0);
    s.wbrd  = 5'($urandom_range(0, 15));
    s.done  = ($urandom_range(0, 3) == 0) && (loads > 0 || !s.ld);
    if ($urandom_range(0, 24) == 0) drain_lvl = !drain_lvl;
    s.drain = drain_lvl;
    return s;
  endfunction

  initial begin
    stim_t s;
    checks_total = 0; checks_passed = 0; drain_lvl = 1'b0;
    foreach (pending[r]) pending[r] = 1'b0;
    loads = 0; mode = M_RUN; stalls = 0;

    reset = 1'b1;
    sb.in_valid = 1'b0; sb.in_rd = '0; sb.in_rs1 = '0; sb.in_rs2 = '0;
    sb.in_rd_valid = 1'b0; sb.in_rs1_valid = 1'b0; sb.in_rs2_valid = 1'b0;
    sb.in_is_load = 1'b0; sb.wb_valid = 1'b0; sb.wb_rd = '0;
    sb.load_done = 1'b0; sb.drain_req = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset cycle with a presented instruction: not ready.
    s = instr(1, 0, 0, 1, 0, 0, 0); s.rst = 1'b1;
    step(s);

    // RAW stall then bypass release.
    step(instr(5, 1, 2, 1, 1, 1, 0));
    step(instr(0, 5, 0, 0, 1, 0, 0));
    check("raw_mask", sb.busy_mask, 32'h20);
    step(instr(0, 5, 0, 0, 1, 0, 0));
    step(instr(0, 5, 0, 0, 1, 0, 0));
    check("raw_stalls", 32'(sb.stall_count), 32'd3);
    s = with_wb(instr(0, 5, 0, 0, 1, 0, 0), 5);
    step(s);
    check("raw_clear", sb.busy_mask, 32'h0);

    // x0 destination never marks busy; reading x0 never stalls.
    step(instr(0, 3, 4, 1, 1, 1, 0));
    step(instr(7, 0, 0, 0, 1, 1, 0));
    check("x0_mask", sb.busy_mask, 32'h0);

    // Load limit; same-cycle load_done does not relieve.
    step(instr(6, 0, 0, 1, 0, 0, 1));
    step(instr(7, 0, 0, 1, 0, 0, 1));
    step(instr(8, 0, 0, 1, 0, 0, 1));
    check("ld_count_full", 32'(sb.load_count), 32'd2);
    s = instr(8, 0, 0, 1, 0, 0, 1); s.done = 1'b1;
    step(s);
    step(instr(8, 0, 0, 1, 0, 0, 1));
    check("ld_count_after", 32'(sb.load_count), 32'd2);
    s = with_wb(idle(), 6); s.done = 1'b1; step(s);
    s = with_wb(idle(), 7); s.done = 1'b1; step(s);
    s = with_wb(idle(), 8); step(s);

    // Same-edge set and clear of x9: set wins.
    step(instr(9, 0, 0, 1, 0, 0, 0));
    step(with_wb(instr(9, 0, 0, 1, 0, 0, 0), 9));
    check("set_wins", 32'(sb.busy_mask[9]), 32'd1);
    step(with_wb(idle(), 9));

    // Drain with two pending writes.
    step(instr(11, 0, 0, 1, 0, 0, 0));
    step(instr(12, 0, 0, 1, 0, 0, 0));
    s = instr(13, 0, 0, 1, 0, 0, 0); s.drain = 1'b1;
    step(s);
    step(s);
    step(with_wb(s, 11));
    step(with_wb(s, 12));
    step(s);
    check("drained_up", 32'(sb.drained), 32'd1);
    step(s);
    step(instr(13, 0, 0, 1, 0, 0, 0));
    step(instr(14, 0, 0, 1, 0, 0, 0));
    check("resume", 32'(sb.busy_mask[14]), 32'd1);

    // Randomized phase.
    s = idle(); s.rst = 1'b1; step(s);
    for (int i = 0; i < 4000; i++) step(rand_stim());

    // Saturating stall counter then mid-stall reset.
    s = idle(); s.rst = 1'b1; step(s);
    step(instr(3, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 66000; i++) step(instr(0, 3, 0, 0, 1, 0, 0));
    check("stall_sat", 32'(sb.stall_count), 32'hFFFF);
    s = instr(0, 3, 0, 0, 1, 0, 0); s.rst = 1'b1;
    step(s);
    check("rst_stall", 32'(sb.stall_count), 32'd0);
    check("rst_mask",  sb.busy_mask, 32'd0);
    check("rst_loads", 32'(sb.load_count), 32'd0);
    step(with_wb(idle(), 3));
    step(idle());

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

In-order issue controller between instruction decode and the execute/memory datapath of the RISC-V core. It takes each decoded instruction together with its register-valid and load flags from decode. It holds the instruction until all of these are clear: RAW hazards on its sources, WAW on its destination, and the outstanding-load limit. It also provides a drain sequence that empties the pipeline, for use by debug and CSR writes.

## Interface
Parameters:
- MAX_LOADS, 2, maximum loads issued but not yet completed (1..7).
- STALL_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  the block's only clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  decode presents an instruction.
- in_rd, in_rs1, in_rs2  in  5 each  register indices from instruction[11:7], [19:15], [24:20].
- in_rd_valid, in_rs1_valid, in_rs2_valid  in  1 each  decode operand-valid flags.
- in_is_load  in  1  instruction uses the memory load port.
- in_ready  out  1  instruction may issue this cycle.
- issue  out  1  in_valid & in_ready; the instruction is accepted this cycle.
- wb_valid  in  1  writeback is completing this cycle.
- wb_rd  in  5  writeback destination.
- load_done  in  1  one outstanding load completed (one-cycle pulse).
- drain_req  in  1  level request to empty the pipeline.
- drained  out  1  pipeline is empty and issue is frozen.
- busy_mask  out  32  pending-write bit per register.
- load_count  out  3  outstanding loads.
- stall_count  out  STALL_W  cycles with in_valid=1 and in_ready=0 while in RUN.

## Operation
- Scoreboard: busy_mask[31:0].
  - Bit r is set on issue when in_rd_valid=1 and in_rd=r.
  - Bit r is cleared on wb_valid when wb_rd=r.
  - Bit 0 is never set, even if in_rd_valid=1 with in_rd=0.
- Same-edge set and clear of the same bit: the set wins, because the newer instruction owns the register.
- Effective busy: eff = busy_mask & ~(wb_valid ? onehot(wb_rd) : 0). A same-cycle writeback counts as a bypass.
- Hazard:
  - (in_rs1_valid & eff[in_rs1]) | (in_rs2_valid & eff[in_rs2]) | (in_rd_valid & eff[in_rd]).
  - Index 0 never produces a hazard.
- Load limit: in_is_load=1 with the registered load_count==MAX_LOADS blocks issue. A load_done in the same cycle does not relieve the block.
- load_count update:
  - +1 on issue of a load; −1 on load_done.
  - Both together: unchanged.
  - load_done at count 0 is ignored.
- in_ready = ~reset & (state==RUN) & ~drain_req & ~hazard & ~load_block.
- FSM (reset → RUN):
  - RUN → DRAIN when drain_req=1. No issue happens in the cycle drain_req is first seen.
  - DRAIN: in_ready=0. Go to DRAINED when busy_mask==0, load_count==0 and wb_valid=0.
  - DRAINED: drained=1 and in_ready=0. Go to RUN when drain_req=0.
  - drain_req dropping while in DRAIN: return to RUN without asserting drained.
- stall_count: +1 per RUN cycle with in_valid=1 and in_ready=0. Saturates at all-ones; never wraps.
- In DRAIN and DRAINED: writebacks and load_done still update busy_mask and load_count.

## Timing
- Reset values: busy_mask=0, load_count=0, state=RUN, drained=0, stall_count=0, in_ready=0 and issue=0 during the reset cycle.
- in_ready and issue are combinational from the in_* fields, wb_valid, wb_rd, drain_req and registered state. They have zero-cycle latency.
- busy_mask, load_count and stall_count update at the edge ending the cycle that caused them; they are visible the next cycle.
- Back-to-back dependency: producer issues in cycle N, so busy bit is set from N+1. Consumer stalls from N+1 and issues in the cycle wb_valid for that register is asserted.
- drained rises one cycle after the cycle in which the empty condition is met in DRAIN. It falls in the cycle after drain_req=0 is sampled.
- Reset asserted mid-operation clears all state on that edge. Outstanding writebacks arriving after reset are ignored (they clear already-clear bits).

## Test plan
- Issue ADD with rd=5, rs1=1, rs2=2, then next cycle SUB with rs1=5 -> SUB stalls, busy_mask=0x20, stall_count increments each cycle. wb_valid with wb_rd=5 -> SUB issues in the same cycle, busy_mask returns to 0 the next cycle.
- Instruction with rd=0, in_rd_valid=1 -> busy_mask stays 0. A following read of x0 issues immediately.
- MAX_LOADS=2: three back-to-back loads to rd=6, 7, 8 -> third stalls with load_count=2. load_done in the stall cycle -> third issues the following cycle, load_count stays 2.
- Same cycle: wb_rd=9 while issuing rd=9 -> busy_mask[9]=1 after the edge.
- drain_req with two pending writes -> in_ready=0. drained=1 one cycle after the last writeback. Drop drain_req -> RUN, and issue resumes the next cycle.
- Force a 70000-cycle stall with STALL_W=16 -> stall_count holds at 0xFFFF. Reset mid-stall -> every counter and mask reads 0 the next cycle.
